// File: rtl/tt_mem_pkg.sv
// Shared types and constants for the two-port byte-RAM arbiter.
package tt_mem_pkg;
  localparam int DEPTH = 800;
  localparam int AW    = 10;
  localparam int DW    = 8;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
    logic is_read;
  } rsp_tag_t;

  // Winner among valid requesters; rr breaks ties. Meaningless when neither is valid.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic rr);
    if (v0 && v1) return rr;
    return !v0;
  endfunction
endpackage

// File: rtl/tt_mem_arbiter.sv
// Round-robin, burst-aware arbiter driving a shared single-port byte RAM.
module tt_mem_arbiter
  import tt_mem_pkg::*;
#(
  parameter int DEPTH     = tt_mem_pkg::DEPTH,
  parameter int AW        = tt_mem_pkg::AW,
  parameter int DW        = tt_mem_pkg::DW,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_last,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_last,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp0_err,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          rsp1_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_t        state, state_nx;
  logic          rr_ptr, rr_nx;
  logic [CW-1:0] beat_cnt, cnt_nx, cnt_inc;
  rsp_tag_t      tag;

  logic          win, g0, g1, acc0, acc1, beat, id, oor;
  logic          sel_we, sel_last;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    win = rr_pick(req0_valid, req1_valid, rr_ptr);
    g0  = 1'b0;
    g1  = 1'b0;
    unique case (state)
      IDLE: begin
        g0 = req0_valid & ~win;
        g1 = req1_valid & win;
      end
      OWN0:    g0 = 1'b1;
      OWN1:    g1 = 1'b1;
      default: ;
    endcase
  end

  // Outputs are held low while reset is asserted so an in-flight beat is neither granted nor answered.
  assign req0_ready = g0 & rst_n;
  assign req1_ready = g1 & rst_n;
  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;
  assign beat = acc0 | acc1;
  assign id   = acc1;

  assign sel_we    = id ? req1_we    : req0_we;
  assign sel_last  = id ? req1_last  : req0_last;
  assign sel_addr  = id ? req1_addr  : req0_addr;
  assign sel_wdata = id ? req1_wdata : req0_wdata;
  assign oor       = 32'(sel_addr) >= 32'(DEPTH);

  assign mem_en    = beat & ~oor;
  assign mem_we    = mem_en & sel_we;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  assign cnt_inc = beat_cnt + CW'(1);

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    cnt_nx   = beat_cnt;
    if (beat) begin
      if (state == IDLE) begin
        if (sel_last || MAX_BURST == 1) begin
          rr_nx = ~id;
        end else begin
          state_nx = id ? OWN1 : OWN0;
          cnt_nx   = CW'(1);
        end
      end else if (sel_last || cnt_inc == CW'(MAX_BURST)) begin
        state_nx = IDLE;
        rr_nx    = ~id;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
      tag      <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_nx;
      beat_cnt <= cnt_nx;
      tag      <= '{valid: beat, id: id, err: oor, is_read: ~sel_we & ~oor};
    end
  end

  // Read data arrives from the RAM a cycle after mem_en, so it is muxed live off the registered tag.
  assign rsp0_valid = rst_n & tag.valid & ~tag.id;
  assign rsp1_valid = rst_n & tag.valid &  tag.id;
  assign rsp0_err   = rsp0_valid & tag.err;
  assign rsp1_err   = rsp1_valid & tag.err;
  assign rsp0_rdata = (rsp0_valid & tag.is_read) ? mem_rdata : '0;
  assign rsp1_rdata = (rsp1_valid & tag.is_read) ? mem_rdata : '0;
endmodule
